// File: rtl/step_sequencer_mixer.sv
// Multi-channel pattern step sequencer and sample mixer feeding the I2S transmitter.
// Optional MIXER_SATURATE_EN clamps the shifted mix instead of wrapping it to OUT_W bits.
module step_sequencer_mixer #(
    parameter int CHANNELS = 4,
    parameter int STEPS    = 8,
    parameter int ADDR_W   = 14,
    parameter int SAMPLE_W = 8,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_sample_tick,
    input  logic                         i_run,
    input  logic [CHANNELS*STEPS-1:0]    i_pattern,
    input  logic [CHANNELS*4-1:0]        i_gain,
    input  logic [CHANNELS*ADDR_W-1:0]   i_sample_len,
    output logic [ADDR_W-1:0]            o_rom_addr,
    input  logic [CHANNELS*SAMPLE_W-1:0] i_rom_data,
    output logic [OUT_W-1:0]             o_mix_out,
    output logic                         o_mix_valid,
    output logic [$clog2(STEPS)-1:0]     o_step,
    output logic                         o_step_strobe,
    output logic                         o_overrun
);
    localparam int STEP_W = $clog2(STEPS);
    localparam int PROD_W = SAMPLE_W + 5;
    localparam int ACC_W  = PROD_W + $clog2(CHANNELS);
    localparam int SH_W   = ACC_W + SHIFT;
    localparam int WIDE_W = (SH_W > OUT_W) ? SH_W : OUT_W;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, ACC, OUT} state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [ADDR_W-1:0]              r_addr;
    logic [STEP_W-1:0]              r_step;
    logic [CHANNELS*STEPS-1:0]      r_pattern_q;
    logic [CHANNELS*SAMPLE_W-1:0]   r_data;
    logic signed [ACC_W-1:0]        r_acc;
    logic                           r_mix_valid;
    logic                           r_step_strobe;
    logic                           r_overrun;
    logic                           r_run_d;

    logic signed [PROD_W-1:0]       w_term [CHANNELS];
    logic signed [ACC_W-1:0]        w_sum;
    logic signed [WIDE_W-1:0]       w_wide;
    logic [OUT_W-1:0]               w_fit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_sample_tick) w_state_next = FETCH;
            FETCH:   w_state_next = ACC;
            ACC:     w_state_next = OUT;
            OUT:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Gain is zero-extended by one bit so the multiply stays signed.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [STEPS-1:0]         w_row;
            logic                     w_en;
            logic signed [PROD_W-1:0] w_prod;
            assign w_row  = r_pattern_q[gi*STEPS +: STEPS];
            assign w_en   = (r_addr < i_sample_len[gi*ADDR_W +: ADDR_W]) && w_row[STEP_LAST - r_step];
            assign w_prod = PROD_W'($signed(r_data[gi*SAMPLE_W +: SAMPLE_W]))
                          * PROD_W'($signed({1'b0, i_gain[gi*4 +: 4]}));
            assign w_term[gi] = w_en ? w_prod : '0;
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_sum = w_sum + ACC_W'(w_term[c]);
        end
    end

    assign w_wide = WIDE_W'(r_acc) <<< SHIFT;

`ifdef MIXER_SATURATE_EN
    localparam logic signed [WIDE_W-1:0] W_MAX = {{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE_W-1:0] W_MIN = {{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    always_comb begin
        w_fit = w_wide[OUT_W-1:0];
        if (w_wide > W_MAX) begin
            w_fit = W_MAX[OUT_W-1:0];
        end else if (w_wide < W_MIN) begin
            w_fit = W_MIN[OUT_W-1:0];
        end
    end
`else
    assign w_fit = w_wide[OUT_W-1:0];
`endif

    // Step, strobe and the pattern snapshot move together at the end of ACC so the
    // new step is visible alongside mix_valid; the address moves one cycle later.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr        <= '0;
            r_step        <= '0;
            r_pattern_q   <= '0;
            r_data        <= '0;
            r_acc         <= '0;
            r_mix_valid   <= 1'b0;
            r_step_strobe <= 1'b0;
            r_overrun     <= 1'b0;
            r_run_d       <= 1'b0;
        end else begin
            r_run_d       <= i_run;
            r_mix_valid   <= (r_state == ACC);
            r_step_strobe <= 1'b0;
            if (i_sample_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (r_state == IDLE && !i_run) begin
                r_addr      <= '0;
                r_step      <= '0;
                r_pattern_q <= '0;
            end else if (i_run && !r_run_d) begin
                r_pattern_q <= i_pattern;
            end
            if (r_state == FETCH) begin
                r_data <= i_rom_data;
            end
            if (r_state == ACC) begin
                r_acc <= w_sum;
                if (i_run && r_addr == ADDR_LAST) begin
                    r_step_strobe <= 1'b1;
                    r_step        <= (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
                    r_pattern_q   <= i_pattern;
                end
            end
            if (r_state == OUT && i_run) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_rom_addr    = r_addr;
    assign o_mix_out     = w_fit;
    assign o_mix_valid   = r_mix_valid;
    assign o_step        = r_step;
    assign o_step_strobe = r_step_strobe;
    assign o_overrun     = r_overrun;
endmodule

// File: tb/tb_step_sequencer_mixer.sv
// Randomised self-checking bench for step_sequencer_mixer with a behavioural ROM and mix model.
module tb_step_sequencer_mixer;
    localparam int CH = 4, ST = 8, AW = 14, SW = 8, OW = 16, SH = 4;
    localparam int NADDR = 1 << AW;

    logic            clk = 1'b0;
    logic            reset, sample_tick, run;
    logic [CH*ST-1:0] pattern;
    logic [CH*4-1:0]  gain;
    logic [CH*AW-1:0] sample_len;
    logic [AW-1:0]    rom_addr;
    logic [CH*SW-1:0] rom_data;
    logic [OW-1:0]    mix_out;
    logic             mix_valid;
    logic [2:0]       step;
    logic             step_strobe, overrun;

    logic [7:0]       mem [CH][NADDR];
    int               gains [CH];
    int               lens [CH];
    int               m_addr, m_step;
    logic [CH*ST-1:0] m_pat;
    logic [OW-1:0]    last_mix;
    int               strobe_seen;
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) rom_data[c*SW +: SW] <= mem[c][rom_addr];
    end

    step_sequencer_mixer #(.CHANNELS(CH), .STEPS(ST), .ADDR_W(AW), .SAMPLE_W(SW), .OUT_W(OW), .SHIFT(SH)) dut (
        .i_clk(clk), .i_reset(reset), .i_sample_tick(sample_tick), .i_run(run),
        .i_pattern(pattern), .i_gain(gain), .i_sample_len(sample_len),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_mix_out(mix_out),
        .o_mix_valid(mix_valid), .o_step(step), .o_step_strobe(step_strobe), .o_overrun(overrun)
    );

    function automatic logic [15:0] fit_model(input longint v);
`ifdef MIXER_SATURATE_EN
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    function automatic logic [15:0] expected_mix();
        int sum = 0;
        for (int c = 0; c < CH; c++) begin
            if (m_addr < lens[c] && m_pat[c*ST + ST - 1 - m_step])
                sum += int'($signed(mem[c][m_addr])) * gains[c];
        end
        return fit_model(longint'(sum) * (64'sd1 <<< SH));
    endfunction

    task automatic apply_cfg();
        for (int c = 0; c < CH; c++) begin
            gain[c*4 +: 4]        = 4'(gains[c]);
            sample_len[c*AW +: AW] = AW'(lens[c]);
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int c = 0; c < CH; c++) for (int a = 0; a < NADDR; a++) mem[c][a] = v;
    endtask

    task automatic fill_random();
        for (int c = 0; c < CH; c++) for (int a = 0; a < NADDR; a++) mem[c][a] = 8'($urandom);
    endtask

    task automatic model_clear();
        m_addr = 0; m_step = 0; m_pat = '0;
    endtask

    task automatic set_run(input bit v);
        bit prev;
        prev = run;
        run = v;
        @(posedge clk); #1;
        if (v && !prev) m_pat = pattern;
        if (!v) model_clear();
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_tick = 1'b0; run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
    endtask

    // One accepted tick: checks latency, the mixed value, step/strobe and the address advance.
    task automatic do_tick(input string name, input bit quiet);
        logic [15:0] exp_mix;
        bit          exp_strobe;
        int          old_addr;
        exp_mix    = expected_mix();
        exp_strobe = run && (m_addr == NADDR - 1);
        old_addr   = m_addr;
        if (run) begin
            if (m_addr == NADDR - 1) begin
                m_addr = 0; m_step = (m_step + 1) % ST; m_pat = pattern;
            end else begin
                m_addr++;
            end
        end
        checks++;
        if (rom_addr !== AW'(old_addr)) begin errors++; $display("FAIL %s pre_addr: got %0d want %0d", name, rom_addr, old_addr); end
        sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        checks++;
        if (mix_valid !== 1'b0) begin errors++; $display("FAIL %s valid_t1: got %b want 0", name, mix_valid); end
        @(posedge clk); #1;
        checks++;
        if (mix_valid !== 1'b0) begin errors++; $display("FAIL %s valid_t2: got %b want 0", name, mix_valid); end
        @(posedge clk); #1;
        checks += 4;
        if (mix_valid !== 1'b1) begin errors++; $display("FAIL %s valid_t3: got %b want 1", name, mix_valid); end
        if (mix_out !== exp_mix) begin errors++; $display("FAIL %s mix_out: got %h want %h", name, mix_out, exp_mix); end
        if (step_strobe !== exp_strobe) begin errors++; $display("FAIL %s strobe: got %b want %b", name, step_strobe, exp_strobe); end
        if (step !== 3'(m_step)) begin errors++; $display("FAIL %s step: got %0d want %0d", name, step, m_step); end
        last_mix = mix_out;
        if (step_strobe === 1'b1) strobe_seen++;
        @(posedge clk); #1;
        checks += 2;
        if (mix_valid !== 1'b0) begin errors++; $display("FAIL %s valid_t4: got %b want 0", name, mix_valid); end
        if (rom_addr !== AW'(m_addr)) begin errors++; $display("FAIL %s post_addr: got %0d want %0d", name, rom_addr, m_addr); end
        if (!quiet) $display("tick %s addr=%0d step=%0d mix=%h exp=%h", name, old_addr, step, mix_out, exp_mix);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (rom_addr !== '0)     begin errors++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
        if (step !== '0)         begin errors++; $display("FAIL reset_step: got %0d want 0", step); end
        if (mix_out !== '0)      begin errors++; $display("FAIL reset_mix: got %h want 0", mix_out); end
        if (mix_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b want 0", mix_valid); end
        if (step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", step_strobe); end
        if (overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset = 1'b0;
        @(posedge clk); #1;
        $display("reset done");
    endtask

    task automatic test_basic();
        fill_const(8'h10);
        for (int c = 0; c < CH; c++) begin gains[c] = 1; lens[c] = NADDR - 1; end
        apply_cfg();
        pattern = '1;
        set_run(1'b1);
        do_tick("basic", 1'b0);
        checks++;
        if (last_mix !== 16'h0400) begin errors++; $display("FAIL basic_const: got %h want 0400", last_mix); end
    endtask

    task automatic test_saturate();
        fill_const(8'h7F);
        for (int c = 0; c < CH; c++) gains[c] = 15;
        apply_cfg();
        do_tick("saturate", 1'b0);
        checks++;
`ifdef MIXER_SATURATE_EN
        if (last_mix !== 16'h7FFF) begin errors++; $display("FAIL saturate_const: got %h want 7fff", last_mix); end
`else
        if (last_mix !== 16'hDC40) begin errors++; $display("FAIL wrap_const: got %h want dc40", last_mix); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        reset = 1'b0;
        fill_random();
        for (int c = 0; c < CH; c++) begin
            gains[c] = int'($urandom_range(0, 15));
            lens[c]  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(20, NADDR - 1));
        end
        apply_cfg();
        pattern = 32'($urandom);
        set_run(1'b1);
        for (int i = 0; i < 24; i++) begin
            gains[i % CH] = int'($urandom_range(0, 15));
            apply_cfg();
            pattern = 32'($urandom);
            do_tick("random", 1'b0);
        end
    endtask

    task automatic test_sample_len();
        logic [15:0] mix99;
        logic [15:0] mix100;
        do_reset();
        reset = 1'b0;
        mem[0][99] = 8'h20; mem[0][100] = 8'h20;
        gains[0] = 3; gains[1] = 0; gains[2] = 0; gains[3] = 0;
        lens[0] = 100; lens[1] = NADDR - 1; lens[2] = NADDR - 1; lens[3] = NADDR - 1;
        apply_cfg();
        pattern = '1;
        set_run(1'b1);
        mix99 = '0; mix100 = '1;
        for (int i = 0; i <= 100; i++) begin
            do_tick("sample_len", 1'b1);
            if (i == 99) mix99 = last_mix;
            if (i == 100) mix100 = last_mix;
        end
        checks += 2;
        if (mix99 !== 16'h0600) begin errors++; $display("FAIL len_addr99: got %h want 0600", mix99); end
        if (mix100 !== 16'h0000) begin errors++; $display("FAIL len_addr100: got %h want 0000", mix100); end
        $display("sample_len addr99=%h addr100=%h", mix99, mix100);
    endtask

    task automatic test_overrun();
        logic [15:0] exp_mix;
        int          pulses;
        exp_mix = expected_mix();
        m_addr++;
        sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        checks += 3;
        if (mix_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", mix_valid); end
        if (mix_out !== exp_mix) begin errors++; $display("FAIL ovr_mix: got %h want %h", mix_out, exp_mix); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (mix_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL ovr_dropped: got %0d extra pulses want 0", pulses); end
        do_tick("after_overrun", 1'b0);
        set_run(1'b0);
        do_tick("stopped", 1'b0);
        checks += 3;
        if (last_mix !== 16'h0000) begin errors++; $display("FAIL stop_mix: got %h want 0000", last_mix); end
        if (step !== 3'd0) begin errors++; $display("FAIL stop_step: got %0d want 0", step); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        $display("overrun test overrun=%b", overrun);
    endtask

    task automatic test_reset_mid_acc();
        int pulses;
        fill_const(8'h10);
        for (int c = 0; c < CH; c++) begin gains[c] = 1; lens[c] = NADDR - 1; end
        apply_cfg();
        pattern = '1;
        set_run(1'b1);
        do_tick("pre_reset", 1'b0);
        sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        model_clear();
        checks += 5;
        if (mix_valid !== 1'b0)  begin errors++; $display("FAIL acc_reset_valid: got %b want 0", mix_valid); end
        if (mix_out !== '0)      begin errors++; $display("FAIL acc_reset_mix: got %h want 0", mix_out); end
        if (rom_addr !== '0)     begin errors++; $display("FAIL acc_reset_addr: got %0d want 0", rom_addr); end
        if (step_strobe !== 1'b0) begin errors++; $display("FAIL acc_reset_strobe: got %b want 0", step_strobe); end
        if (overrun !== 1'b0)    begin errors++; $display("FAIL acc_reset_overrun: got %b want 0", overrun); end
        reset = 1'b0; run = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mix_valid === 1'b1) pulses++;
        end
        reset = 1'b1; sample_tick = 1'b1;
        @(posedge clk); #1 reset = 1'b0; sample_tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mix_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_abort: got %0d pulses want 0", pulses); end
        $display("reset abort test pulses=%0d", pulses);
    endtask

    task automatic test_long_run();
        int strobe_at;
        do_reset();
        reset = 1'b0;
        fill_random();
        for (int c = 0; c < CH; c++) begin
            gains[c] = int'($urandom_range(1, 15));
            lens[c]  = int'($urandom_range(NADDR / 2, NADDR - 1));
        end
        apply_cfg();
        pattern = 32'($urandom);
        set_run(1'b1);
        strobe_seen = 0;
        strobe_at = -1;
        for (int i = 0; i < NADDR; i++) begin
            if (i == 100) pattern = 32'($urandom);
            do_tick("long", 1'b1);
            if (strobe_seen == 1 && strobe_at < 0) strobe_at = i;
        end
        checks += 3;
        if (strobe_at != NADDR - 1) begin errors++; $display("FAIL wrap_strobe_at: got %0d want %0d", strobe_at, NADDR - 1); end
        if (step !== 3'd1) begin errors++; $display("FAIL wrap_step: got %0d want 1", step); end
        if (rom_addr !== '0) begin errors++; $display("FAIL wrap_addr: got %0d want 0", rom_addr); end
        $display("long run ticks=%0d strobe_at=%0d step=%0d", NADDR, strobe_at, step);
        for (int i = 0; i < 3; i++) do_tick("step1", 1'b0);
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; run = 1'b0;
        pattern = '0; gain = '0; sample_len = '0;
        strobe_seen = 0; last_mix = '0;
        for (int c = 0; c < CH; c++) begin gains[c] = 0; lens[c] = 0; end
        fill_const(8'h00);
        model_clear();
        test_reset();
        test_basic();
        test_saturate();
        test_random();
        test_sample_len();
        test_overrun();
        test_reset_mid_acc();
        test_long_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/step_sequencer_mixer.md
# step_sequencer_mixer

Parametrised multi-channel drum/sample step sequencer and mixer. It walks a STEPS-long pattern at one step per STEP_LEN audio samples. On every codec sample tick it fetches one sample per channel from synchronous sample ROMs, gates each sample by the pattern bit, scales it by a per-channel gain and sums the channels. The signed, width-fitted mix goes to the I2S transmitter. It is the single-clock successor of the fixed 4-channel/8-step manager and sits between the LRCLK edge detector and the codec serializer.

## Interface
- CHANNELS, 4, number of sample channels (1..8)
- STEPS, 8, pattern steps per bar (2..32)
- ADDR_W, 14, sample address width; STEP_LEN = 2**ADDR_W samples per step
- SAMPLE_W, 8, signed ROM sample width
- OUT_W, 16, signed mix output width
- SHIFT, 4, left shift applied to the accumulated sum before width fitting
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle pulse per audio frame (from LRCLK edge detector)
- run  in  1  1 = sequencer advances; 0 = stopped, position cleared, silence output
- pattern  in  CHANNELS*STEPS  channel c, step s enable = pattern[c*STEPS + (STEPS-1-s)]
- gain  in  CHANNELS*4  unsigned per-channel gain 0..15, channel c at [c*4 +: 4]
- sample_len  in  CHANNELS*ADDR_W  per-channel sample length; addresses >= length read as 0
- rom_addr  out  ADDR_W  registered address shared by all channel ROMs
- rom_data  in  CHANNELS*SAMPLE_W  ROM outputs, one cycle after rom_addr, channel c at [c*SAMPLE_W +: SAMPLE_W]
- mix_out  out  OUT_W  signed mixed sample, held between updates
- mix_valid  out  1  one-cycle pulse when mix_out updates
- step  out  $clog2(STEPS)  current step index
- step_strobe  out  1  one-cycle pulse when step changes
- overrun  out  1  sticky: a sample_tick arrived while the pipeline was busy

## Operation
- FSM states are IDLE, FETCH, ACC and OUT.
  - IDLE -> FETCH on sample_tick.
  - FETCH -> ACC unconditionally. rom_data for rom_addr is captured here.
  - ACC -> OUT unconditionally. The products and sum are registered here.
  - OUT -> IDLE unconditionally. mix_out is registered and mix_valid is pulsed.
- A sample_tick seen in any state other than IDLE is dropped and sets overrun. overrun clears only on Reset.
- Channel term = (addr < sample_len[c] && pattern_q bit for current step) ? signed(rom_data[c]) * gain[c] : 0.
  - The product is signed, SAMPLE_W+5 bits wide.
- The accumulator is SAMPLE_W+5+$clog2(CHANNELS) bits, signed. It is shifted left by SHIFT and then fitted to OUT_W.
- pattern_q is a snapshot of `pattern`. It is captured on the run 0->1 edge and on every step advance. Edits made mid-step take effect at the next step.
- Position update happens in the OUT state when run=1:
  - addr increments modulo STEP_LEN.
  - On the wrap from STEP_LEN-1 to 0, step increments modulo STEPS and step_strobe pulses in the same cycle as mix_valid.
- run=0:
  - addr, step and pattern_q are held at 0 in IDLE.
  - Ticks still produce mix_valid, with mix_out=0.
  - If run falls mid-pipeline, the in-flight sample completes normally and the position clears on return to IDLE.
- Reset values: state IDLE, rom_addr 0, step 0, mix_out 0, mix_valid 0, step_strobe 0, overrun 0, pattern_q 0.
  - Reset in any state aborts the in-flight sample. No mix_valid is produced for it.

## Timing
- sample_tick in cycle T is followed by mix_valid in cycle T+3. mix_out is valid from T+3 until the next update.
- rom_addr changes in cycle T+4, which leaves the ROMs a full cycle before the next FETCH.
- Minimum tick spacing is 4 cycles; closer ticks set overrun.
- Simultaneous sample_tick and Reset: Reset wins and the tick is discarded.
- The rom_addr register drives the ROMs directly, with no combinational path from sample_tick.

## Configuration
- MIXER_SATURATE_EN defined: a shifted sum above 2**(OUT_W-1)-1 clamps to +max, and one below -2**(OUT_W-1) clamps to -max.
- MIXER_SATURATE_EN undefined: the shifted sum is truncated to its low OUT_W bits (two's-complement wrap).

## Test plan
- Reset mid-ACC -> no mix_valid follows; all outputs are 0 next cycle.
- CHANNELS=4, gains 1, pattern all ones, rom_data all 8'h10, tick -> mix_valid at T+3 with mix_out = 4*16<<4 = 16'h0400.
- Channel 0 data 8'h7F, gain 15, other channels 8'h7F, gain 15 -> mix_out 16'h7FFF with MIXER_SATURATE_EN. Without it, 7620<<4 = 121920 truncates to 16'hDC40.
- Run 2**14 ticks from reset with run=1 -> step goes 0->1 with step_strobe in the same cycle as the 16384th mix_valid, and rom_addr returns to 0.
- sample_len[0]=100, rom_data nonzero -> channel 0 contributes at addr 99 and contributes 0 at addr 100.
- Ticks 2 cycles apart -> second tick ignored, overrun=1 and sticky. Then run=0 -> next tick gives mix_out 0 and step 0.
